// File: rtl/cpu_defs.sv
// Shared encodings for the control unit: opcodes, ALU ops, register-field selects, FSM states.
// Pure definitions, no logic.
package cpu_defs;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SHR = 5'b00100;
    localparam logic [4:0] ALU_SHL = 5'b00101;

    // One-hot {Gra, Grb, Grc} field selects.
    localparam logic [2:0] SEL_GRA = 3'b100;
    localparam logic [2:0] SEL_GRB = 3'b010;
    localparam logic [2:0] SEL_GRC = 3'b001;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef struct packed {
        logic rtype;
        logic itype;
        logic ld;
        logic st;
        logic nop;
        logic halt;
    } iclass_t;

endpackage

// File: rtl/opcode_decode.sv
// Classifies the 5-bit opcode into an instruction class and picks the ALU op.
// Purely combinational; unknown opcodes are treated as nop.
module opcode_decode
    import cpu_defs::*;
(
    input  logic [4:0] opcode,
    output iclass_t    cls,
    output logic [4:0] alu_op
);

    always_comb begin
        cls    = '0;
        alu_op = ALU_ADD;
        case (opcode)
            OP_LD:   cls.ld = 1'b1;
            OP_ST:   cls.st = 1'b1;
            OP_ADD:  cls.rtype = 1'b1;
            OP_SUB:  begin cls.rtype = 1'b1; alu_op = ALU_SUB; end
            OP_AND:  begin cls.rtype = 1'b1; alu_op = ALU_AND; end
            OP_OR:   begin cls.rtype = 1'b1; alu_op = ALU_OR;  end
            OP_SHR:  begin cls.rtype = 1'b1; alu_op = ALU_SHR; end
            OP_SHL:  begin cls.rtype = 1'b1; alu_op = ALU_SHL; end
            OP_ADDI: cls.itype = 1'b1;
            OP_ANDI: begin cls.itype = 1'b1; alu_op = ALU_AND; end
            OP_ORI:  begin cls.itype = 1'b1; alu_op = ALU_OR;  end
            OP_HALT: cls.halt = 1'b1;
            default: cls.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control FSM: fetch T0-T2, execute T3-T7, one state per clock except memory waits.
// Waits in T1 / ld T6 / st T7 until Mem_Ready; Clear low forces RST and all-zero outputs at once.
module control_unit (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Mem_Ready,
    input  logic        Stop,
    output logic        PC_Out,
    output logic        MDR_Out,
    output logic        ZLO_Out,
    output logic        PC_In,
    output logic        MAR_In,
    output logic        MDR_In,
    output logic        IR_In,
    output logic        Y_In,
    output logic        ZLO_In,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  CONTROL,
    output logic [2:0]  Gr_Sel,
    output logic        R_In,
    output logic        R_Out,
    output logic        BA_Out,
    output logic        C_Out,
    output logic        Run
);
    import cpu_defs::*;

    state_t     state_q, state_d, end_state;
    iclass_t    cls;
    logic [4:0] alu_op;

    // Operand fields are consumed by the datapath, not here.
    logic unused_ir;
    assign unused_ir = ^IR[26:0];

    opcode_decode u_dec (
        .opcode (IR[31:27]),
        .cls    (cls),
        .alu_op (alu_op)
    );

    // Stop only matters on an instruction's final step.
    assign end_state = Stop ? S_HALT : S_T0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (Mem_Ready) state_d = S_T2;
            S_T2: begin
                if (cls.halt)     state_d = S_HALT;
                else if (cls.nop) state_d = end_state;
                else              state_d = S_T3;
            end
            S_T3:   state_d = S_T4;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (cls.ld || cls.st) ? S_T6 : end_state;
            S_T6:   if (cls.st || Mem_Ready) state_d = S_T7;
            S_T7:   if (cls.ld || Mem_Ready) state_d = end_state;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state_q <= S_RST;
        else        state_q <= state_d;
    end

    always_comb begin
        {PC_Out, MDR_Out, ZLO_Out, PC_In, MAR_In, MDR_In, IR_In, Y_In, ZLO_In} = '0;
        {IncPC, Read, Write, R_In, R_Out, BA_Out, C_Out} = '0;
        CONTROL = ALU_ADD;
        Gr_Sel  = '0;
        Run     = (state_q != S_RST) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin PC_Out = 1'b1; MAR_In = 1'b1; IncPC = 1'b1; ZLO_In = 1'b1; end
            S_T1: begin
                ZLO_Out = 1'b1; Read = 1'b1; MDR_In = 1'b1;
                PC_In   = Mem_Ready;
            end
            S_T2: begin MDR_Out = 1'b1; IR_In = 1'b1; end
            S_T3: begin
                Gr_Sel = SEL_GRB; Y_In = 1'b1;
                if (cls.ld || cls.st) BA_Out = 1'b1;
                else                  R_Out  = 1'b1;
            end
            S_T4: begin
                ZLO_In  = 1'b1;
                CONTROL = alu_op;
                if (cls.rtype) begin Gr_Sel = SEL_GRC; R_Out = 1'b1; end
                else           C_Out = 1'b1;
            end
            S_T5: begin
                ZLO_Out = 1'b1;
                if (cls.ld || cls.st) MAR_In = 1'b1;
                else begin Gr_Sel = SEL_GRA; R_In = 1'b1; end
            end
            S_T6: begin
                MDR_In = 1'b1;
                if (cls.st) begin Gr_Sel = SEL_GRA; R_Out = 1'b1; end
                else        Read = 1'b1;
            end
            S_T7: begin
                if (cls.st) Write = 1'b1;
                else begin MDR_Out = 1'b1; Gr_Sel = SEL_GRA; R_In = 1'b1; end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: every output is packed into one vector
// and compared step by step against hand-built expected patterns.
module tb_control_unit;

    logic        Clock, Clear, Mem_Ready, Stop;
    logic [31:0] IR;
    logic        PC_Out, MDR_Out, ZLO_Out, PC_In, MAR_In, MDR_In, IR_In, Y_In, ZLO_In;
    logic        IncPC, Read, Write, R_In, R_Out, BA_Out, C_Out, Run;
    logic [4:0]  CONTROL;
    logic [2:0]  Gr_Sel;
    logic [24:0] outv;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_Ready(Mem_Ready), .Stop(Stop),
        .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .PC_In(PC_In),
        .MAR_In(MAR_In), .MDR_In(MDR_In), .IR_In(IR_In), .Y_In(Y_In), .ZLO_In(ZLO_In),
        .IncPC(IncPC), .Read(Read), .Write(Write), .CONTROL(CONTROL), .Gr_Sel(Gr_Sel),
        .R_In(R_In), .R_Out(R_Out), .BA_Out(BA_Out), .C_Out(C_Out), .Run(Run)
    );

    assign outv = {PC_Out, MDR_Out, ZLO_Out, PC_In, MAR_In, MDR_In, IR_In, Y_In, ZLO_In,
                   IncPC, Read, Write, R_In, R_Out, BA_Out, C_Out, Run, Gr_Sel, CONTROL};

    localparam logic [24:0] PCO  = 25'd1 << 24;
    localparam logic [24:0] MDRO = 25'd1 << 23;
    localparam logic [24:0] ZLOO = 25'd1 << 22;
    localparam logic [24:0] PCI  = 25'd1 << 21;
    localparam logic [24:0] MARI = 25'd1 << 20;
    localparam logic [24:0] MDRI = 25'd1 << 19;
    localparam logic [24:0] IRI  = 25'd1 << 18;
    localparam logic [24:0] YI   = 25'd1 << 17;
    localparam logic [24:0] ZLOI = 25'd1 << 16;
    localparam logic [24:0] INC  = 25'd1 << 15;
    localparam logic [24:0] RD   = 25'd1 << 14;
    localparam logic [24:0] WR   = 25'd1 << 13;
    localparam logic [24:0] RIN  = 25'd1 << 12;
    localparam logic [24:0] ROUT = 25'd1 << 11;
    localparam logic [24:0] BAO  = 25'd1 << 10;
    localparam logic [24:0] COUT = 25'd1 << 9;
    localparam logic [24:0] RUN  = 25'd1 << 8;
    localparam logic [24:0] GA   = 25'b100 << 5;
    localparam logic [24:0] GB   = 25'b010 << 5;
    localparam logic [24:0] GC   = 25'b001 << 5;
    localparam logic [24:0] NONE = 25'd0;

    localparam logic [24:0] E_T0    = RUN | PCO | MARI | INC | ZLOI;
    localparam logic [24:0] E_T1W   = RUN | ZLOO | RD | MDRI;
    localparam logic [24:0] E_T1X   = RUN | ZLOO | RD | MDRI | PCI;
    localparam logic [24:0] E_T2    = RUN | MDRO | IRI;
    localparam logic [24:0] E_T3R   = RUN | GB | ROUT | YI;
    localparam logic [24:0] E_T5R   = RUN | ZLOO | GA | RIN;
    localparam logic [24:0] E_T3M   = RUN | GB | BAO | YI;
    localparam logic [24:0] E_T4M   = RUN | COUT | ZLOI;
    localparam logic [24:0] E_T5M   = RUN | ZLOO | MARI;
    localparam logic [24:0] E_LD_T6 = RUN | RD | MDRI;
    localparam logic [24:0] E_LD_T7 = RUN | MDRO | GA | RIN;
    localparam logic [24:0] E_ST_T6 = RUN | GA | ROUT | MDRI;
    localparam logic [24:0] E_ST_T7 = RUN | WR;

    // add, sub, and, or, shr, shl with their ALU codes 0..5
    localparam logic [31:0] R_IR [6] = '{32'h18000000, 32'h20A48000, 32'h28000000,
                                          32'h30000000, 32'h38000000, 32'h40000000};
    localparam logic [31:0] I_IR [3] = '{32'h60812345, 32'h68000000, 32'h70000000};
    localparam logic [4:0]  I_CTL[3] = '{5'b00000, 5'b00010, 5'b00011};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [24:0] exp);
        @(posedge Clock);
        #1;
        check(tag, outv, exp);
    endtask

    task automatic run_rtype(input logic [31:0] ir, input logic [4:0] ctl);
        IR = ir;
        step("rt_t1", E_T1X);
        step("rt_t2", E_T2);
        step("rt_t3", E_T3R);
        step("rt_t4", RUN | GC | ROUT | ZLOI | 25'(ctl));
        step("rt_t5", E_T5R);
        step("rt_t0", E_T0);
    endtask

    task automatic run_itype(input logic [31:0] ir, input logic [4:0] ctl);
        IR = ir;
        step("it_t1", E_T1X);
        step("it_t2", E_T2);
        step("it_t3", E_T3R);
        step("it_t4", RUN | COUT | ZLOI | 25'(ctl));
        step("it_t5", E_T5R);
        step("it_t0", E_T0);
    endtask

    initial begin
        Clear = 1'b0; IR = 32'h18000000; Mem_Ready = 1'b1; Stop = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_outputs", outv, NONE);
        Clear = 1'b1;
        step("first_t0", E_T0);

        for (int i = 0; i < 6; i++) run_rtype(R_IR[i], 5'(i));
        for (int i = 0; i < 3; i++) run_itype(I_IR[i], I_CTL[i]);

        // ld with fetch wait in T1 and 3 extra cycles in T6
        IR = 32'h00000000; Mem_Ready = 1'b0;
        step("ld_t1_wait", E_T1W);
        step("ld_t1_wait2", E_T1W);
        Mem_Ready = 1'b1;
        #1 check("ld_t1_exit", outv, E_T1X);
        step("ld_t2", E_T2);
        step("ld_t3", E_T3M);
        step("ld_t4", E_T4M);
        step("ld_t5", E_T5M);
        Mem_Ready = 1'b0;
        step("ld_t6", E_LD_T6);
        for (int i = 0; i < 3; i++) step("ld_t6_hold", E_LD_T6);
        Mem_Ready = 1'b1;
        step("ld_t7", E_LD_T7);
        step("ld_t0", E_T0);

        // st with 2 wait cycles in T7
        IR = 32'h10000000;
        step("st_t1", E_T1X);
        step("st_t2", E_T2);
        step("st_t3", E_T3M);
        step("st_t4", E_T4M);
        step("st_t5", E_T5M);
        step("st_t6", E_ST_T6);
        Mem_Ready = 1'b0;
        step("st_t7", E_ST_T7);
        step("st_t7_hold1", E_ST_T7);
        step("st_t7_hold2", E_ST_T7);
        Mem_Ready = 1'b1;
        step("st_t0", E_T0);

        // Stop only in T3: ignored
        IR = 32'h20000000;
        step("sub_t1", E_T1X);
        step("sub_t2", E_T2);
        step("sub_t3", E_T3R);
        Stop = 1'b1;
        step("sub_t4", RUN | GC | ROUT | ZLOI | 25'd1);
        Stop = 1'b0;
        step("sub_t5", E_T5R);
        step("sub_nohalt_t0", E_T0);

        // Stop in T3 and on the final step: halts after T5
        step("sub2_t1", E_T1X);
        step("sub2_t2", E_T2);
        step("sub2_t3", E_T3R);
        Stop = 1'b1;
        step("sub2_t4", RUN | GC | ROUT | ZLOI | 25'd1);
        Stop = 1'b0;
        step("sub2_t5", E_T5R);
        Stop = 1'b1;
        step("sub2_halt", NONE);
        Stop = 1'b0;
        step("sub2_halt_hold", NONE);
        Clear = 1'b0;
        #1 check("stop_clear", outv, NONE);
        Clear = 1'b1;
        step("stop_restart_t0", E_T0);

        // nop and an unknown opcode end at T2
        IR = 32'hC0000000;
        step("nop_t1", E_T1X);
        step("nop_t2", E_T2);
        step("nop_t0", E_T0);
        IR = 32'hF8000000;
        step("unk_t1", E_T1X);
        step("unk_t2", E_T2);
        step("unk_t0", E_T0);

        // halt opcode
        IR = 32'hC8000000;
        step("halt_t1", E_T1X);
        step("halt_t2", E_T2);
        step("halt_state", NONE);
        Mem_Ready = 1'b0;
        step("halt_hold", NONE);
        Mem_Ready = 1'b1;
        Clear = 1'b0;
        #1 check("halt_clear", outv, NONE);
        Clear = 1'b1;
        step("halt_rst_t0", E_T0);

        // Clear asserted during the T1 memory wait, between edges
        IR = 32'h18000000; Mem_Ready = 1'b0;
        step("clr_t1_wait", E_T1W);
        #3 Clear = 1'b0;
        #1 check("clr_async", outv, NONE);
        Clear = 1'b1; Mem_Ready = 1'b1;
        step("clr_restart_t0", E_T0);
        step("clr_restart_t1", E_T1X);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
